// File: rtl/count_reporter_pkg.sv
// Shared types and helpers for count_uart_reporter: UART FSM states,
// ASCII constants and the 4-bit value to ASCII hex mapping.
package count_reporter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
    if (v < 4'd10) return ASCII_ZERO + {4'd0, v};
    else           return ASCII_A + {4'd0, v - 4'd10};
  endfunction

endpackage

// File: rtl/count_uart_reporter_if.sv
// Port bundle of count_uart_reporter: counter input, overrun clear,
// and the UART/status outputs.
interface count_uart_reporter_if;
  logic [3:0] count_i;
  logic       ovr_clr_i;
  logic       tx_o;
  logic       busy_o;
  logic       overrun_o;

  modport master (output count_i, ovr_clr_i, input tx_o, busy_o, overrun_o);
  modport slave  (input count_i, ovr_clr_i, output tx_o, busy_o, overrun_o);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake. A new byte is accepted
// from IDLE or at the very end of STOP so characters can go back-to-back.
module uart_tx_byte
  import count_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       WB_CLK,
  input  logic       WB_RSTn,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge WB_CLK) begin
    shreg_q <= shreg_d;
  end

  assign bit_end = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          state_d = START;
          shreg_d = data;
          tmr_d   = TMR_LOAD;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tmr_d   = TMR_LOAD;
          bit_d   = 3'd0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          tmr_d   = TMR_LOAD;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          ready = 1'b1;
          if (valid) begin
            state_d = START;
            shreg_d = data;
            tmr_d   = TMR_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/count_uart_reporter.sv
// Reports every change of the 4-bit event counter as an ASCII hex digit on
// an 8N1 UART. Define COUNT_REPORTER_CRLF_EN to follow each digit with CR LF.
module count_uart_reporter
  import count_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RSTn,
  count_uart_reporter_if.slave  bus
);

  logic [3:0] prev_q;
  logic [3:0] pend_val_q;
  logic       pend_q;
  logic       ovr_q;
  logic       chg;
  logic       take;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_line;
  logic [7:0] tx_data;

  assign chg = (bus.count_i != prev_q);

`ifdef COUNT_REPORTER_CRLF_EN
  // Index of the next character to hand to the serializer; 0 starts a message.
  logic [1:0] idx_q;

  always_comb begin
    tx_valid = 1'b1;
    tx_data  = ASCII_LF;
    case (idx_q)
      2'd0: begin
        tx_valid = pend_q && !tx_busy;
        tx_data  = hex_to_ascii(pend_val_q);
      end
      2'd1:    tx_data = ASCII_CR;
      default: tx_data = ASCII_LF;
    endcase
  end

  assign take = tx_valid && tx_ready && (idx_q == 2'd0);

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      idx_q <= 2'd0;
    end else if (tx_valid && tx_ready) begin
      idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end
`else
  assign tx_valid = pend_q && !tx_busy;
  assign tx_data  = hex_to_ascii(pend_val_q);
  assign take     = tx_valid && tx_ready;
`endif

  // A new change beats the hand-off on the same edge, so it is never lost.
  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      prev_q <= 4'd0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      prev_q <= bus.count_i;
      if (chg)       pend_q <= 1'b1;
      else if (take) pend_q <= 1'b0;
      if (chg && pend_q && !take) ovr_q <= 1'b1;
      else if (bus.ovr_clr_i)     ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (chg) pend_val_q <= bus.count_i;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .WB_CLK  (WB_CLK),
    .WB_RSTn (WB_RSTn),
    .valid   (tx_valid),
    .data    (tx_data),
    .ready   (tx_ready),
    .tx      (tx_line),
    .busy    (tx_busy)
  );

  assign bus.tx_o      = tx_line;
  assign bus.busy_o    = tx_busy;
  assign bus.overrun_o = ovr_q;

endmodule
